// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the instruction decode unit: the opcode-class
// enum, fixed opcode constants and the classify() helper that maps an 8-bit
// program-memory word onto its class.
//
// Encoding:
//    0ddd_iiii  LOAD imm to reg d
//    10dd_dsss  MOVE reg s to reg d (d == s is a NOP)
//    110f_ffff  ALU op f, result to reg 0
//    1110_aaaa  JMP
//    1111_aaaa  JNZ
// -----------------------------------------------------------------------------
package isa_pkg;

   typedef enum logic [2:0] {
      CLS_LOAD = 3'd0,
      CLS_MOVE = 3'd1,
      CLS_ALU  = 3'd2,
      CLS_JMP  = 3'd3,
      CLS_JNZ  = 3'd4,
      CLS_NOP  = 3'd5
   } instr_class_e;

   localparam logic [3:0] OPC_JMP  = 4'hE;
   localparam logic [3:0] OPC_JNZ  = 4'hF;
   localparam logic [7:0] NOP_WORD = 8'h80;

   // Map a program word onto its opcode class; a MOVE onto itself is a NOP.
   function automatic instr_class_e classify(input logic [7:0] i_word);
      instr_class_e v_class;
      if (i_word[7] == 1'b0) begin
         v_class = CLS_LOAD;
      end else if (i_word[6] == 1'b0) begin
         if (i_word[5:3] == i_word[2:0]) begin
            v_class = CLS_NOP;
         end else begin
            v_class = CLS_MOVE;
         end
      end else if (i_word[5] == 1'b0) begin
         v_class = CLS_ALU;
      end else if (i_word[7:4] == OPC_JMP) begin
         v_class = CLS_JMP;
      end else if (i_word[7:4] == OPC_JNZ) begin
         v_class = CLS_JNZ;
      end else begin
         v_class = CLS_NOP;
      end
      return v_class;
   endfunction

endpackage

// File: rtl/instr_decode_unit_if.sv
// -----------------------------------------------------------------------------
// instr_decode_unit_if
// Bundle between the fetch/ALU side and the instruction decode unit.
//   pm_data     instruction word at current pc (to decoder)
//   alu_zero    ALU zero result of the op in execute (to decoder)
//   jmp/jmp_nz  jump requests to the sequencer (combinational fetch decode)
//   jmp_addr    jump target nibble
//   dont_jmp    zero condition true, suppresses jmp_nz
//   ir          execute-stage instruction register
//   reg_en      one-hot destination write enable
//   src_sel     move source select
//   imm         load immediate
//   alu_en      execute stage holds an ALU op
//   alu_func    ALU function code
//   retired_cnt retired-instruction count (only with INSTR_COUNT_EN)
// Modports: master = driver of pm_data/alu_zero, slave = the decoder.
// -----------------------------------------------------------------------------
interface instr_decode_unit_if #(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3
`ifdef INSTR_COUNT_EN
   , parameter int CNT_W   = 16
`endif
);

   logic [7:0]           pm_data;
   logic                 alu_zero;
   logic                 jmp;
   logic                 jmp_nz;
   logic [3:0]           jmp_addr;
   logic                 dont_jmp;
   logic [7:0]           ir;
   logic [NUM_REGS-1:0]  reg_en;
   logic [REG_SEL_W-1:0] src_sel;
   logic [3:0]           imm;
   logic                 alu_en;
   logic [4:0]           alu_func;
`ifdef INSTR_COUNT_EN
   logic [CNT_W-1:0]     retired_cnt;

   modport master (
      output pm_data, alu_zero,
      input  jmp, jmp_nz, jmp_addr, dont_jmp, ir, reg_en, src_sel, imm,
             alu_en, alu_func, retired_cnt
   );
   modport slave (
      input  pm_data, alu_zero,
      output jmp, jmp_nz, jmp_addr, dont_jmp, ir, reg_en, src_sel, imm,
             alu_en, alu_func, retired_cnt
   );
`else
   modport master (
      output pm_data, alu_zero,
      input  jmp, jmp_nz, jmp_addr, dont_jmp, ir, reg_en, src_sel, imm,
             alu_en, alu_func
   );
   modport slave (
      input  pm_data, alu_zero,
      output jmp, jmp_nz, jmp_addr, dont_jmp, ir, reg_en, src_sel, imm,
             alu_en, alu_func
   );
`endif

endinterface

// File: rtl/instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Pure combinational class/field extractor for one program word.
//   i_word      instruction word
//   o_class     opcode class
//   o_reg_en    one-hot destination enable (zero for JMP/JNZ/NOP)
//   o_src_sel   move source (zero unless MOVE)
//   o_imm       load immediate (zero unless LOAD)
//   o_alu_en    word is an ALU op
//   o_alu_func  ALU function (zero unless ALU)
//   o_jmp_addr  jump target nibble (raw low nibble)
// -----------------------------------------------------------------------------
module instr_field_decode
   import isa_pkg::*;
#(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3
) (
   input  logic [7:0]           i_word,
   output instr_class_e         o_class,
   output logic [NUM_REGS-1:0]  o_reg_en,
   output logic [REG_SEL_W-1:0] o_src_sel,
   output logic [3:0]           o_imm,
   output logic                 o_alu_en,
   output logic [4:0]           o_alu_func,
   output logic [3:0]           o_jmp_addr
);

   instr_class_e w_class;

   assign w_class    = classify(i_word);
   assign o_class    = w_class;
   assign o_jmp_addr = i_word[3:0];

   // Field extraction per class; everything not owned by the class stays zero.
   always_comb begin
      o_reg_en   = {NUM_REGS{1'b0}};
      o_src_sel  = {REG_SEL_W{1'b0}};
      o_imm      = 4'h0;
      o_alu_en   = 1'b0;
      o_alu_func = 5'h00;
      case (w_class)
         CLS_LOAD: begin
            o_reg_en = NUM_REGS'(1'b1) << i_word[6:4];
            o_imm    = i_word[3:0];
         end
         CLS_MOVE: begin
            o_reg_en  = NUM_REGS'(1'b1) << i_word[5:3];
            o_src_sel = REG_SEL_W'(i_word[2:0]);
         end
         CLS_ALU: begin
            // ALU results always land in register 0
            o_reg_en   = NUM_REGS'(1'b1);
            o_alu_en   = 1'b1;
            o_alu_func = i_word[4:0];
         end
         default: begin
            o_reg_en = {NUM_REGS{1'b0}};
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_unit.sv
// -----------------------------------------------------------------------------
// instr_decode_unit
// Instruction decoder feeding the program sequencer.
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   dec_bus  instr_decode_unit_if.slave: pm_data/alu_zero in; jmp, jmp_nz,
//            jmp_addr, dont_jmp (combinational), ir, reg_en, src_sel, imm,
//            alu_en, alu_func (execute stage, one cycle after fetch) out.
// Optional feature macro: INSTR_COUNT_EN adds dec_bus.retired_cnt, a wrapping
// count of executed non-NOP instructions.
// -----------------------------------------------------------------------------
module instr_decode_unit
   import isa_pkg::*;
#(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3
`ifdef INSTR_COUNT_EN
   , parameter int CNT_W   = 16
`endif
) (
   input  logic                clk,
   input  logic                reset,
   instr_decode_unit_if.slave  dec_bus
);

   // Fetch-path decode
   instr_class_e         w_fetch_class;
   logic [NUM_REGS-1:0]  w_fetch_reg_en;
   logic [REG_SEL_W-1:0] w_fetch_src_sel;
   logic [3:0]           w_fetch_imm;
   logic                 w_fetch_alu_en;
   logic [4:0]           w_fetch_alu_func;
   logic [3:0]           w_fetch_jmp_addr;

   // Execute-register input decode
   instr_class_e         w_exec_class;
   logic [NUM_REGS-1:0]  w_exec_reg_en;
   logic [REG_SEL_W-1:0] w_exec_src_sel;
   logic [3:0]           w_exec_imm;
   logic                 w_exec_alu_en;
   logic [4:0]           w_exec_alu_func;
   logic [3:0]           w_exec_jmp_addr;

   logic                 w_jmp;
   logic                 w_jmp_nz;
   logic                 w_dont_jmp;
   logic                 w_unused_fields;

   logic [7:0]           r_ir;
   logic [NUM_REGS-1:0]  r_reg_en;
   logic [REG_SEL_W-1:0] r_src_sel;
   logic [3:0]           r_imm;
   logic                 r_alu_en;
   logic [4:0]           r_alu_func;
   logic                 r_z_flag;

   instr_field_decode #(
      .NUM_REGS  (NUM_REGS),
      .REG_SEL_W (REG_SEL_W)
   ) u_fetch_decode (
      .i_word     (dec_bus.pm_data),
      .o_class    (w_fetch_class),
      .o_reg_en   (w_fetch_reg_en),
      .o_src_sel  (w_fetch_src_sel),
      .o_imm      (w_fetch_imm),
      .o_alu_en   (w_fetch_alu_en),
      .o_alu_func (w_fetch_alu_func),
      .o_jmp_addr (w_fetch_jmp_addr)
   );

   instr_field_decode #(
      .NUM_REGS  (NUM_REGS),
      .REG_SEL_W (REG_SEL_W)
   ) u_exec_decode (
      .i_word     (dec_bus.pm_data),
      .o_class    (w_exec_class),
      .o_reg_en   (w_exec_reg_en),
      .o_src_sel  (w_exec_src_sel),
      .o_imm      (w_exec_imm),
      .o_alu_en   (w_exec_alu_en),
      .o_alu_func (w_exec_alu_func),
      .o_jmp_addr (w_exec_jmp_addr)
   );

   // Each decoder instance only feeds part of its outputs onward.
   assign w_unused_fields = ^{w_fetch_reg_en, w_fetch_src_sel, w_fetch_imm,
                              w_fetch_alu_en, w_fetch_alu_func,
                              (w_exec_class == CLS_NOP), w_exec_jmp_addr};

   // Jump requests are zero-latency from the fetched word, held off in reset.
   always_comb begin
      w_jmp    = 1'b0;
      w_jmp_nz = 1'b0;
      if (reset) begin
         w_jmp    = 1'b0;
         w_jmp_nz = 1'b0;
      end else begin
         w_jmp    = (w_fetch_class == CLS_JMP);
         w_jmp_nz = (w_fetch_class == CLS_JNZ);
      end
   end

   // Zero condition bypass: an ALU op in execute supplies its live result,
   // so a JNZ fetched right behind it does not wait for z_flag.
   always_comb begin
      w_dont_jmp = 1'b1;
      if (r_alu_en) begin
         w_dont_jmp = dec_bus.alu_zero;
      end else begin
         w_dont_jmp = r_z_flag;
      end
   end

   // Execute stage: capture the fetched word and its decoded controls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir       <= NOP_WORD;
         r_reg_en   <= {NUM_REGS{1'b0}};
         r_src_sel  <= {REG_SEL_W{1'b0}};
         r_imm      <= 4'h0;
         r_alu_en   <= 1'b0;
         r_alu_func <= 5'h00;
      end else begin
         r_ir       <= dec_bus.pm_data;
         r_reg_en   <= w_exec_reg_en;
         r_src_sel  <= w_exec_src_sel;
         r_imm      <= w_exec_imm;
         r_alu_en   <= w_exec_alu_en;
         r_alu_func <= w_exec_alu_func;
      end
   end

   // Zero flag: latch the ALU result of each executed ALU op, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_z_flag <= 1'b1;
      end else if (r_alu_en) begin
         r_z_flag <= dec_bus.alu_zero;
      end else begin
         r_z_flag <= r_z_flag;
      end
   end

`ifdef INSTR_COUNT_EN
   logic [CNT_W-1:0] r_retired_cnt;

   // Count each edge whose execute-stage word is a real instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retired_cnt <= {CNT_W{1'b0}};
      end else if (classify(r_ir) != CLS_NOP) begin
         r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_retired_cnt <= r_retired_cnt;
      end
   end

   assign dec_bus.retired_cnt = r_retired_cnt;
`endif

   assign dec_bus.jmp      = w_jmp;
   assign dec_bus.jmp_nz   = w_jmp_nz;
   assign dec_bus.jmp_addr = w_fetch_jmp_addr;
   assign dec_bus.dont_jmp = w_dont_jmp;
   assign dec_bus.ir       = r_ir;
   assign dec_bus.reg_en   = r_reg_en;
   assign dec_bus.src_sel  = r_src_sel;
   assign dec_bus.imm      = r_imm;
   assign dec_bus.alu_en   = r_alu_en;
   assign dec_bus.alu_func = r_alu_func;

endmodule

// File: tb/tb_instr_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_unit
// Self-checking bench for instr_decode_unit. Inputs change on the falling
// edge; combinational outputs are checked 1 ns later, registered outputs on
// the following falling edge. A numeric reference model tracks the word in
// execute, the zero flag and (with INSTR_COUNT_EN) the retired count.
// -----------------------------------------------------------------------------
module tb_instr_decode_unit;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   instr_decode_unit_if bus ();

   instr_decode_unit dut (
      .clk     (clk),
      .reset   (reset),
      .dec_bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_ir;
   logic        m_z;
   logic [15:0] m_cnt;

   // Reference decode written from the encoding table as numeric ranges
   function automatic bit m_is_nop(input logic [7:0] w);
      return (w >= 8'h80 && w < 8'hC0 && ((w / 8) % 8) == (w % 8));
   endfunction
   function automatic bit m_is_alu(input logic [7:0] w);
      return (w >= 8'hC0 && w < 8'hE0);
   endfunction
   function automatic logic [7:0] m_reg_en(input logic [7:0] w);
      int d;
      if (w < 8'h80) begin d = w / 16; return 8'(1 << d); end
      if (w < 8'hC0) begin
         if (m_is_nop(w)) return 8'h00;
         d = (w / 8) % 8;
         return 8'(1 << d);
      end
      if (w < 8'hE0) return 8'h01;
      return 8'h00;
   endfunction
   function automatic logic [2:0] m_src(input logic [7:0] w);
      if (w >= 8'h80 && w < 8'hC0 && !m_is_nop(w)) return 3'(w % 8);
      return 3'd0;
   endfunction
   function automatic logic [3:0] m_imm(input logic [7:0] w);
      if (w < 8'h80) return 4'(w % 16);
      return 4'h0;
   endfunction
   function automatic logic [4:0] m_func(input logic [7:0] w);
      if (m_is_alu(w)) return 5'(w - 8'hC0);
      return 5'd0;
   endfunction

   task automatic m_reset();
      m_ir  = 8'h80;
      m_z   = 1'b1;
      m_cnt = 16'd0;
   endtask

   task automatic drive(input logic [7:0] w, input logic z);
      bus.pm_data  = w;
      bus.alu_zero = z;
   endtask

   // One rising edge: advance the model, then return at the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!m_is_nop(m_ir)) m_cnt = m_cnt + 16'd1;
      if (m_is_alu(m_ir)) m_z = bus.alu_zero;
      m_ir = bus.pm_data;
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(8'h3A, 1'b0);
      reset = 1'b0;
      m_reset();
      #1;
      checks++; if (bus.ir !== 8'h80) begin errors++; $display("FAIL rst_ir: got %h expected 80", bus.ir); end
      checks++; if (bus.reg_en !== 8'h00) begin errors++; $display("FAIL rst_reg_en: got %h expected 00", bus.reg_en); end
      checks++; if (bus.dont_jmp !== 1'b1) begin errors++; $display("FAIL rst_dont_jmp: got %b expected 1", bus.dont_jmp); end
      checks++; if (bus.alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en: got %b expected 0", bus.alu_en); end
      @(negedge clk);
      tick();
      drive(8'hE5, 1'b0);
      #1;
      checks++; if (bus.jmp !== 1'b1) begin errors++; $display("FAIL pre_rst_jmp: got %b expected 1", bus.jmp); end
      #1 reset = 1'b1;
      #1;
      checks++; if (bus.jmp !== 1'b0) begin errors++; $display("FAIL rst_jmp: got %b expected 0", bus.jmp); end
      checks++; if (bus.ir !== 8'h80) begin errors++; $display("FAIL rst_async_ir: got %h expected 80", bus.ir); end
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      #1;
      checks++; if (bus.ir !== 8'h80) begin errors++; $display("FAIL rel_ir: got %h expected 80", bus.ir); end
      checks++; if (bus.reg_en !== 8'h00) begin errors++; $display("FAIL rel_reg_en: got %h expected 00", bus.reg_en); end
      checks++; if (bus.dont_jmp !== 1'b1) begin errors++; $display("FAIL rel_dont_jmp: got %b expected 1", bus.dont_jmp); end
   endtask

   task automatic test_load_move_nop();
      drive(8'h3A, 1'b0); tick();
      checks++; if (bus.reg_en !== 8'b0000_1000) begin errors++; $display("FAIL load_reg_en: got %b expected 00001000", bus.reg_en); end
      checks++; if (bus.imm !== 4'hA) begin errors++; $display("FAIL load_imm: got %h expected a", bus.imm); end
      checks++; if (bus.alu_en !== 1'b0) begin errors++; $display("FAIL load_alu_en: got %b expected 0", bus.alu_en); end
      drive(8'h9A, 1'b0); tick();
      checks++; if (bus.reg_en !== 8'b0000_1000) begin errors++; $display("FAIL move_reg_en: got %b expected 00001000", bus.reg_en); end
      checks++; if (bus.src_sel !== 3'd2) begin errors++; $display("FAIL move_src: got %0d expected 2", bus.src_sel); end
      checks++; if (bus.imm !== 4'h0) begin errors++; $display("FAIL move_imm: got %h expected 0", bus.imm); end
      drive(8'h92, 1'b0); tick();
      checks++; if (bus.reg_en !== 8'h00) begin errors++; $display("FAIL nop_reg_en: got %b expected 0", bus.reg_en); end
      checks++; if (bus.ir !== 8'h92) begin errors++; $display("FAIL nop_ir: got %h expected 92", bus.ir); end
   endtask

   task automatic test_jmp();
      drive(8'hE7, 1'b0);
      #1;
      checks++; if (bus.jmp !== 1'b1 || bus.jmp_nz !== 1'b0) begin errors++; $display("FAIL jmp_req: got %b%b expected 10", bus.jmp, bus.jmp_nz); end
      checks++; if (bus.jmp_addr !== 4'h7) begin errors++; $display("FAIL jmp_addr: got %h expected 7", bus.jmp_addr); end
      tick();
      checks++; if (bus.reg_en !== 8'h00 || bus.alu_en !== 1'b0) begin errors++; $display("FAIL jmp_bubble: got reg_en %h alu_en %b expected 00 0", bus.reg_en, bus.alu_en); end
   endtask

   task automatic test_alu_jnz_bypass();
      for (int k = 0; k < 2; k++) begin
         drive(8'hC3, 1'b0); tick();
         checks++; if (bus.alu_en !== 1'b1 || bus.alu_func !== 5'd3 || bus.reg_en !== 8'h01) begin
            errors++; $display("FAIL alu_exec: got en %b func %0d reg_en %h expected 1 3 01", bus.alu_en, bus.alu_func, bus.reg_en); end
         drive(8'hF4, (k == 0) ? 1'b1 : 1'b0);
         #1;
         checks++; if (bus.jmp_nz !== 1'b1) begin errors++; $display("FAIL bypass_jmp_nz: got %b expected 1", bus.jmp_nz); end
         checks++; if (bus.dont_jmp !== ((k == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL bypass_dont_jmp: got %b expected %b", bus.dont_jmp, (k == 0)); end
         tick();
      end
   endtask

   task automatic test_flag_hold();
      for (int k = 0; k < 2; k++) begin
         drive(8'hC1, 1'b0); tick();
         drive(8'h3A, k[0]); tick();
         drive(8'hF0, ~k[0]);
         #1;
         checks++; if (bus.dont_jmp !== k[0]) begin errors++; $display("FAIL hold_dont_jmp: got %b expected %b", bus.dont_jmp, k[0]); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [7:0] w;
      logic       z;
      logic       exp_dj;
      for (int n = 0; n < 400; n++) begin
         w = 8'($urandom);
         z = 1'($urandom);
         drive(w, z);
         exp_dj = m_is_alu(m_ir) ? z : m_z;
         #1;
         checks++; if (bus.jmp !== (w / 16 == 14) || bus.jmp_nz !== (w / 16 == 15) || bus.jmp_addr !== 4'(w % 16)) begin
            errors++; $display("FAIL rnd_fetch: word %h got %b%b %h", w, bus.jmp, bus.jmp_nz, bus.jmp_addr); end
         checks++; if (bus.dont_jmp !== exp_dj) begin errors++; $display("FAIL rnd_dont_jmp: got %b expected %b", bus.dont_jmp, exp_dj); end
         if ($urandom_range(0, 39) == 0) begin
            #1 reset = 1'b1;
            #1;
            checks++; if (bus.jmp !== 1'b0 || bus.jmp_nz !== 1'b0 || bus.ir !== 8'h80 || bus.reg_en !== 8'h00) begin
               errors++; $display("FAIL rnd_reset: got jmp %b jnz %b ir %h reg_en %h", bus.jmp, bus.jmp_nz, bus.ir, bus.reg_en); end
            @(negedge clk);
            reset = 1'b0;
            m_reset();
         end else begin
            tick();
            checks++; if (bus.ir !== m_ir) begin errors++; $display("FAIL rnd_ir: got %h expected %h", bus.ir, m_ir); end
            checks++; if (bus.reg_en !== m_reg_en(m_ir)) begin errors++; $display("FAIL rnd_reg_en: ir %h got %h expected %h", m_ir, bus.reg_en, m_reg_en(m_ir)); end
            checks++; if (bus.src_sel !== m_src(m_ir) || bus.imm !== m_imm(m_ir)) begin
               errors++; $display("FAIL rnd_src_imm: ir %h got %0d %h expected %0d %h", m_ir, bus.src_sel, bus.imm, m_src(m_ir), m_imm(m_ir)); end
            checks++; if (bus.alu_en !== m_is_alu(m_ir) || bus.alu_func !== m_func(m_ir)) begin
               errors++; $display("FAIL rnd_alu: ir %h got %b %0d expected %b %0d", m_ir, bus.alu_en, bus.alu_func, m_is_alu(m_ir), m_func(m_ir)); end
`ifdef INSTR_COUNT_EN
            checks++; if (bus.retired_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt: got %0d expected %0d", bus.retired_cnt, m_cnt); end
`endif
         end
      end
   endtask

`ifdef INSTR_COUNT_EN
   task automatic test_count();
      logic [7:0] words [7];
      words = '{8'h3A, 8'h9A, 8'hC3, 8'hE7, 8'hF4, 8'h80, 8'h92};
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      for (int i = 0; i < 7; i++) begin
         drive(words[i], 1'b0); tick();
      end
      checks++; if (bus.retired_cnt !== 16'd5) begin errors++; $display("FAIL cnt_five: got %0d expected 5", bus.retired_cnt); end
      drive(8'h3A, 1'b0);
      while (m_cnt != 16'hFFFF) tick();
      checks++; if (bus.retired_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max: got %h expected ffff", bus.retired_cnt); end
      tick();
      checks++; if (bus.retired_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000", bus.retired_cnt); end
   endtask
`endif

   initial begin
      bus.pm_data  = 8'h00;
      bus.alu_zero = 1'b0;
      m_reset();
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_load_move_nop();
      test_jmp();
      test_alu_jnz_bypass();
      test_flag_hold();
      test_random();
`ifdef INSTR_COUNT_EN
      test_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
